alu_bist: RTL and testbench
===========================

# alu_bist

Built-in self-test engine for the CPU's combinational ALU. It drives the ALU operand and function inputs from a seeded LFSR, walking all sixteen supported ALUfun codes. It compacts every ALU result into a 32-bit MISR signature and compares that signature against a golden value. It sits beside the ALU in the datapath and is invoked at power-up or from a debug path.

## Interface
Parameters:
- SEED, 32'h1ACE_B00C, LFSR seed. Must be nonzero.
- VECTORS, 64, operand vectors applied per ALUfun code. Legal range 1..65536.
- GOLDEN, 32'h0000_0000, expected final signature.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately when low.
- start  in  1  run request, sampled only in IDLE and DONE.
- busy  out  1  high while the test is running.
- done  out  1  high in DONE; holds until the next start or reset.
- pass  out  1  (signature == GOLDEN); valid only while done=1, otherwise 0.
- signature  out  32  current MISR contents.
- alu_A  out  32  ALU operand A (registered).
- alu_B  out  32  ALU operand B (registered).
- alu_ALUfun  out  6  ALU function code (registered).
- alu_Sign  out  1  ALU signed-compare select (registered).
- alu_S  in  32  ALU result (combinational from the four outputs above).

## Operation
- States: IDLE, LOAD, SAMPLE, DONE.
- Reset values: state IDLE; busy, done, pass = 0; signature, alu_A, alu_B = 0; alu_ALUfun = 6'b000000; alu_Sign = 0; lfsr = SEED; op_idx = 0; vec_idx = 0.
- IDLE or DONE with start=1 moves to LOAD and performs the run initialisation:
  - lfsr <= SEED, signature <= 0, op_idx <= 0, vec_idx <= 0, done <= 0.
- LOAD (1 cycle) moves to SAMPLE:
  - alu_A <= lfsr and alu_B <= step(lfsr), then lfsr <= step(step(lfsr)).
  - alu_ALUfun <= OPS[op_idx]; alu_Sign <= vec_idx[0].
- SAMPLE (1 cycle):
  - signature <= {signature[30:0],1'b0} ^ (signature[31] ? 32'h04C1_1DB7 : 0) ^ alu_S.
  - If vec_idx == VECTORS-1: vec_idx <= 0 and op_idx increments. Otherwise vec_idx increments.
  - After the last vector of op_idx 15, go to DONE; otherwise go to LOAD.
- step(x) = x[0] ? (x>>1) ^ 32'h8020_0003 : x>>1 (right-shift Galois LFSR).
- OPS order, indices 0..15: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, A 011010, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, GEZ 111001, GTZ 111111.
- Shift amounts come from alu_A[4:0]; no masking is applied.
- In DONE, the ALU outputs hold their final values and signature is frozen.
- start during LOAD or SAMPLE is ignored.

## Timing
- Two cycles per vector. busy is high for exactly 32*VECTORS cycles.
- busy rises on the edge that samples start; done and pass are valid on the edge after the final SAMPLE.
- alu_S is sampled at the end of SAMPLE, one full cycle after the registered ALU inputs change, so there is no combinational path from alu_S to any output.
- reset low at any time forces the reset values asynchronously. Releasing reset returns to IDLE; no run resumes.
- A start pulse in DONE begins a fresh run. Identical ALU behaviour yields an identical signature.

## Test plan
- Reset check: reset low, then released -> every output matches its reset value; with start held 0 for 20 cycles, busy stays 0.
- Full run with a behavioural ALU model, VECTORS=4, GOLDEN set to the model-computed signature:
  - start pulse -> busy high exactly 128 cycles.
  - Then done=1, pass=1, and signature equals the model value.
- Sequence check, VECTORS=1:
  - first LOAD -> alu_A=32'h1ACE_B00C, alu_B=32'h0D67_5806, alu_ALUfun=000000, alu_Sign=0.
  - second LOAD -> alu_A=32'h06B3_AC03, alu_ALUfun=000001.
  - alu_ALUfun then follows OPS order through 111111.
- Fault injection, VECTORS=4: flip alu_S[0] during a single SAMPLE of the SRA op -> final signature differs from the golden value and pass=0.
- Start handling: start pulses during busy -> no effect on the cycle count or signature; start in DONE -> a second run with a bit-identical signature.
- Reset mid-run (reset low at busy cycle 50, then start again) -> outputs zero asynchronously, and the new run's signature equals that of an uninterrupted run.

Source files
------------

// File: rtl/alu_bist.sv
// alu_bist: built-in self-test engine for the CPU's combinational ALU.
//
// A Galois LFSR supplies operand pairs, and the engine walks the sixteen
// supported ALUfun codes with VECTORS vectors per code. Every ALU result is
// folded into a 32-bit MISR. When the run ends, the signature is compared
// against GOLDEN.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-low
//   start      : run request, honoured only in IDLE and DONE
//   busy       : high while a run is in progress (LOAD/SAMPLE)
//   done       : high in DONE, holds until next start or reset
//   pass       : signature == GOLDEN, qualified by done
//   signature  : current MISR contents
//   alu_A/B    : registered ALU operands
//   alu_ALUfun : registered ALU function code
//   alu_Sign   : registered signed-compare select
//   alu_S      : ALU result, sampled at the end of SAMPLE
module alu_bist #(
    parameter logic [31:0] SEED    = 32'h1ACE_B00C,
    parameter int          VECTORS = 64,
    parameter logic [31:0] GOLDEN  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] signature,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [5:0]  alu_ALUfun,
    output logic        alu_Sign,
    input  logic [31:0] alu_S
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
    localparam logic [15:0] LAST_VEC  = 16'(VECTORS - 1);

    // Right-shift Galois LFSR step.
    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ LFSR_TAPS) : (x >> 1);
    endfunction

    // Function codes, in the order they are exercised.
    function automatic logic [5:0] op_code(input logic [3:0] idx);
        logic [5:0] c;
        case (idx)
            4'd0:    c = 6'b000000; // ADD
            4'd1:    c = 6'b000001; // SUB
            4'd2:    c = 6'b011000; // AND
            4'd3:    c = 6'b011110; // OR
            4'd4:    c = 6'b010110; // XOR
            4'd5:    c = 6'b010001; // NOR
            4'd6:    c = 6'b011010; // A
            4'd7:    c = 6'b100000; // SLL
            4'd8:    c = 6'b100001; // SRL
            4'd9:    c = 6'b100011; // SRA
            4'd10:   c = 6'b110011; // EQ
            4'd11:   c = 6'b110001; // NEQ
            4'd12:   c = 6'b110101; // LT
            4'd13:   c = 6'b111101; // LEZ
            4'd14:   c = 6'b111001; // GEZ
            default: c = 6'b111111; // GTZ
        endcase
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [3:0]  op_idx_q, op_idx_d;
    logic [15:0] vec_idx_q, vec_idx_d;
    logic [31:0] sig_q, sig_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [5:0]  fun_q, fun_d;
    logic        sign_q, sign_d;
    logic        done_q, done_d;

    logic [31:0] lfsr_s1;
    logic        last_vec;

    assign lfsr_s1  = lfsr_step(lfsr_q);
    assign last_vec = (vec_idx_q == LAST_VEC);

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        op_idx_d  = op_idx_q;
        vec_idx_d = vec_idx_q;
        sig_d     = sig_q;
        a_d       = a_q;
        b_d       = b_q;
        fun_d     = fun_q;
        sign_d    = sign_q;
        done_d    = done_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // ALU outputs are left alone so they hold across DONE.
                if (start) begin
                    state_d   = S_LOAD;
                    lfsr_d    = SEED;
                    sig_d     = '0;
                    op_idx_d  = '0;
                    vec_idx_d = '0;
                    done_d    = 1'b0;
                end
            end
            S_LOAD: begin
                a_d     = lfsr_q;
                b_d     = lfsr_s1;
                lfsr_d  = lfsr_step(lfsr_s1);
                fun_d   = op_code(op_idx_q);
                sign_d  = vec_idx_q[0];
                state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                // alu_S has had a full cycle to settle from the registered inputs.
                sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'h0) ^ alu_S;
                if (last_vec) begin
                    vec_idx_d = '0;
                    op_idx_d  = op_idx_q + 4'd1;
                end else begin
                    vec_idx_d = vec_idx_q + 16'd1;
                end
                if (last_vec && (op_idx_q == 4'd15)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            lfsr_q    <= SEED;
            op_idx_q  <= '0;
            vec_idx_q <= '0;
            sig_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            fun_q     <= '0;
            sign_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            op_idx_q  <= op_idx_d;
            vec_idx_q <= vec_idx_d;
            sig_q     <= sig_d;
            a_q       <= a_d;
            b_q       <= b_d;
            fun_q     <= fun_d;
            sign_q    <= sign_d;
            done_q    <= done_d;
        end
    end

    assign busy       = (state_q == S_LOAD) || (state_q == S_SAMPLE);
    assign done       = done_q;
    // Built only from registers, so alu_S never reaches an output combinationally.
    assign pass       = done_q && (sig_q == GOLDEN);
    assign signature  = sig_q;
    assign alu_A      = a_q;
    assign alu_B      = b_q;
    assign alu_ALUfun = fun_q;
    assign alu_Sign   = sign_q;

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist. The main instance (VECTORS=4) drives a
// behavioural ALU. The second instance (VECTORS=1) has alu_S tied to zero,
// which keeps its signature at 0 so that GOLDEN=0 must give pass=1.
module tb_alu_bist;

    localparam logic [31:0] SEED = 32'h1ACE_B00C;
    localparam logic [5:0]  SRA  = 6'b100011;

    logic        clk = 1'b0;
    logic        rst_n, start, start1, inj;
    logic        busy, done, pass, alu_Sign;
    logic [31:0] signature, alu_A, alu_B, alu_S;
    logic [5:0]  alu_ALUfun;
    logic        busy1, done1, pass1, alu_Sign1;
    logic [31:0] signature1, alu_A1, alu_B1;
    logic [5:0]  alu_ALUfun1;
    logic [31:0] zero32;

    int n_cmp = 0;
    int n_err = 0;

    logic [5:0] ops [16] = '{6'b000000, 6'b000001, 6'b011000, 6'b011110,
                             6'b010110, 6'b010001, 6'b011010, 6'b100000,
                             6'b100001, 6'b100011, 6'b110011, 6'b110001,
                             6'b110101, 6'b111101, 6'b111001, 6'b111111};

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] f, input logic s);
        case (f)
            6'b000000: return a + b;
            6'b000001: return a - b;
            6'b011000: return a & b;
            6'b011110: return a | b;
            6'b010110: return a ^ b;
            6'b010001: return ~(a | b);
            6'b011010: return a;
            6'b100000: return b << a[4:0];
            6'b100001: return b >> a[4:0];
            6'b100011: return $unsigned($signed(b) >>> a[4:0]);
            6'b110011: return {31'b0, a == b};
            6'b110001: return {31'b0, a != b};
            6'b110101: return {31'b0, s ? ($signed(a) < $signed(b)) : (a < b)};
            6'b111101: return {31'b0, $signed(a) <= 32'sd0};
            6'b111001: return {31'b0, $signed(a) >= 32'sd0};
            6'b111111: return {31'b0, $signed(a) > 32'sd0};
            default:   return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    // Reference signature for a whole run; fault_vec flips bit 0 of one result.
    function automatic logic [31:0] model_sig(input int vectors, input int fault_vec);
        logic [31:0] l, a, b, s, sig;
        l   = SEED;
        sig = 32'h0;
        for (int op = 0; op < 16; op++) begin
            for (int v = 0; v < vectors; v++) begin
                a = l;
                b = step(l);
                l = step(b);
                s = alu_f(a, b, ops[op], v[0]);
                if (op * vectors + v == fault_vec) s = s ^ 32'h1;
                sig = {sig[30:0], 1'b0} ^ (sig[31] ? 32'h04C1_1DB7 : 32'h0) ^ s;
            end
        end
        return sig;
    endfunction

    assign alu_S  = alu_f(alu_A, alu_B, alu_ALUfun, alu_Sign) ^ {31'b0, inj};
    assign zero32 = 32'h0;

    alu_bist #(.SEED(SEED), .VECTORS(4), .GOLDEN(32'h0)) dut (
        .clk(clk), .reset(rst_n), .start(start),
        .busy(busy), .done(done), .pass(pass), .signature(signature),
        .alu_A(alu_A), .alu_B(alu_B), .alu_ALUfun(alu_ALUfun),
        .alu_Sign(alu_Sign), .alu_S(alu_S)
    );

    alu_bist #(.SEED(SEED), .VECTORS(1), .GOLDEN(32'h0)) dut1 (
        .clk(clk), .reset(rst_n), .start(start1),
        .busy(busy1), .done(done1), .pass(pass1), .signature(signature1),
        .alu_A(alu_A1), .alu_B(alu_B1), .alu_ALUfun(alu_ALUfun1),
        .alu_Sign(alu_Sign1), .alu_S(zero32)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse start on the main instance and count busy cycles (sampled on negedges).
    // noise=1 also pulses start while busy; those must be ignored.
    task automatic do_run(input int max_cyc, input bit noise, output int cycles);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 0;
        while (busy && cycles < max_cyc) begin
            cycles++;
            start = noise && (cycles % 7 == 3);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_good, exp_fault;
        int          cyc;
        bit          found;

        exp_good  = model_sig(4, -1);
        exp_fault = model_sig(4, 36); // first SRA vector

        rst_n = 1'b0; start = 1'b0; start1 = 1'b0; inj = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset values.
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_sig", signature, 0);
        chk("rst_A", alu_A, 0);
        chk("rst_B", alu_B, 0);
        chk("rst_fun", alu_ALUfun, 0);
        chk("rst_sign", alu_Sign, 0);
        chk("rst_sig1", signature1, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_busy", {busy, busy1}, 0);
        end

        // Sequence check on the VECTORS=1 instance.
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("seq_busy_rise", busy1, 1);
        @(negedge clk);
        chk("seq_A0", alu_A1, 32'h1ACE_B00C);
        chk("seq_B0", alu_B1, 32'h0D67_5806);
        chk("seq_fun0", alu_ALUfun1, 6'b000000);
        chk("seq_sign0", alu_Sign1, 0);
        for (int op = 1; op < 16; op++) begin
            repeat (2) @(negedge clk);
            if (op == 1) chk("seq_A1", alu_A1, 32'h06B3_AC03);
            chk("seq_fun", alu_ALUfun1, ops[op]);
        end
        @(negedge clk);
        chk("seq_done1", done1, 1);
        chk("seq_pass1", pass1, 1);
        chk("seq_busy1", busy1, 0);
        chk("seq_sig1", signature1, 0);

        // Full run with the behavioural ALU.
        do_run(1000, 1'b0, cyc);
        chk("run1_cycles", cyc, 128);
        chk("run1_done", done, 1);
        chk("run1_sig", signature, exp_good);
        chk("run1_pass", pass, (exp_good == 32'h0));
        repeat (3) @(negedge clk);
        chk("done_hold", done, 1);
        chk("done_sig_frozen", signature, exp_good);

        // Start from DONE with noise pulses while busy.
        do_run(1000, 1'b1, cyc);
        chk("run2_cycles", cyc, 128);
        chk("run2_done", done, 1);
        chk("run2_sig", signature, exp_good);

        // Fault injection on one SRA sample.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (alu_ALUfun == SRA) found = 1'b1;
            else @(negedge clk);
        end
        chk("fault_found_sra", found, 1);
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        chk("fault_done", done, 1);
        chk("fault_sig", signature, exp_fault);
        chk("fault_differs", (signature != exp_good), 1);
        chk("fault_pass", pass, 0);

        // Reset mid-run, then a clean run.
        do_run(50, 1'b0, cyc);
        chk("mid_cycles", cyc, 50);
        chk("mid_still_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_sig", signature, 0);
        chk("arst_A", alu_A, 0);
        chk("arst_B", alu_B, 0);
        chk("arst_fun", alu_ALUfun, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("no_resume", busy, 0);
        do_run(1000, 1'b0, cyc);
        chk("run3_cycles", cyc, 128);
        chk("run3_sig", signature, exp_good);
        chk("run3_done", done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
